// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter that shares one N-bit register between
// four requesters. It captures the winning requester's word and holds it valid
// until the consumer acknowledges it. All state changes on the falling edge of clk.
//
// Ports:
//   clk      in   clock (falling-edge active)
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0]  per-requester load request
//   d0..d3   in   [N-1:0] requester data words
//   q_ack    in   consumer accepts q (only while q_valid)
//   gnt      out  [3:0]  one-cycle one-hot pulse marking the capture edge
//   q        out  [N-1:0] shared register contents
//   q_valid  out  q holds an unconsumed word
//   q_src    out  [1:0]  index of the requester whose word is in q
module reg_share_arbiter #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic         q_ack,
    output logic [3:0]   gnt,
    output logic [N-1:0] q,
    output logic         q_valid,
    output logic [1:0]   q_src
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;

    logic          win_found_c;
    logic [IW-1:0] win_idx_c;
    logic [N-1:0]  win_data_c;
    logic          load_c;

    // Rotating priority search starting at ptr; 2-bit index wraps naturally.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            logic [IW-1:0] idx;
            idx = ptr + IW'(k);
            if (!win_found_c && req[idx]) begin
                win_found_c = 1'b1;
                win_idx_c   = idx;
            end
        end
    end

    // Data select for the winner.
    always_comb begin
        win_data_c = d0;
        case (win_idx_c)
            2'd0:    win_data_c = d0;
            2'd1:    win_data_c = d1;
            2'd2:    win_data_c = d2;
            default: win_data_c = d3;
        endcase
    end

    // A load happens from IDLE on any request, or from HOLD when the held word
    // is acknowledged and another request is pending (back-to-back).
    always_comb begin
        load_c = 1'b0;
        case (state)
            IDLE:    load_c = win_found_c;
            HOLD:    load_c = q_ack && win_found_c;
            default: load_c = 1'b0;
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            q       <= '0;
            q_src   <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
        end else begin
            gnt <= '0;
            if (load_c) begin
                state   <= HOLD;
                q       <= win_data_c;
                q_src   <= win_idx_c;
                q_valid <= 1'b1;
                gnt     <= NREQ'(1) << win_idx_c;
                ptr     <= win_idx_c + IW'(1);
            end else if (state == HOLD && q_ack) begin
                // Acknowledged with nothing pending: release, q keeps its value.
                state   <= IDLE;
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter (N=5).
module tb_reg_share_arbiter;

    localparam int unsigned N = 5;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [N-1:0] d0, d1, d2, d3;
    logic         q_ack;
    logic [3:0]   gnt;
    logic [N-1:0] q;
    logic         q_valid;
    logic [1:0]   q_src;

    int n_checks = 0;
    int n_fail   = 0;

    reg_share_arbiter #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .q_ack   (q_ack),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_src   (q_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [N-1:0] e_q,
                           input logic e_v, input logic [1:0] e_src);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".q"}, 32'(q), 32'(e_q));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(e_v));
        chk({tag, ".q_src"}, 32'(q_src), 32'(e_src));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        q_ack = 1'b0;
        d0 = 5'h01; d1 = 5'h02; d2 = 5'h03; d3 = 5'h04;
        tick();
        tick();
        chk_all("reset", 4'b0000, 5'h00, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Full contention with ack tied high: grants 0,1,2,3,0, no valid gap.
        req = 4'b1111; q_ack = 1'b1;
        tick(); chk_all("rr0", 4'b0001, 5'h01, 1'b1, 2'd0);
        tick(); chk_all("rr1", 4'b0010, 5'h02, 1'b1, 2'd1);
        tick(); chk_all("rr2", 4'b0100, 5'h03, 1'b1, 2'd2);
        tick(); chk_all("rr3", 4'b1000, 5'h04, 1'b1, 2'd3);
        tick(); chk_all("rr4", 4'b0001, 5'h01, 1'b1, 2'd0);
        req = 4'b0000;
        tick(); chk_all("rr_release", 4'b0000, 5'h01, 1'b0, 2'd0);

        // Pointer wrap: grant 3 (ptr->0), then 0 beats 3, then 3 beats 0.
        req = 4'b1000; q_ack = 1'b0;
        tick(); chk_all("wrap_g3", 4'b1000, 5'h04, 1'b1, 2'd3);
        req = 4'b1001; q_ack = 1'b1;
        tick(); chk_all("wrap_g0", 4'b0001, 5'h01, 1'b1, 2'd0);
        tick(); chk_all("wrap_g3b", 4'b1000, 5'h04, 1'b1, 2'd3);
        req = 4'b0000;
        tick(); chk_all("wrap_release", 4'b0000, 5'h04, 1'b0, 2'd3);

        // Ack while idle is ignored; then a single load with ack already high.
        tick(); chk_all("idle_ack1", 4'b0000, 5'h04, 1'b0, 2'd3);
        tick(); chk_all("idle_ack2", 4'b0000, 5'h04, 1'b0, 2'd3);
        req = 4'b0001;
        tick(); chk_all("idle_load", 4'b0001, 5'h01, 1'b1, 2'd0);
        req = 4'b0000; q_ack = 1'b0;
        tick(); chk_all("idle_hold", 4'b0000, 5'h01, 1'b1, 2'd0);
        q_ack = 1'b1;
        tick(); chk_all("idle_release", 4'b0000, 5'h01, 1'b0, 2'd0);

        // Single request, delayed ack; data and new requests ignored while held.
        req = 4'b0010; d1 = 5'h15; q_ack = 1'b0;
        tick(); chk_all("hold_load", 4'b0010, 5'h15, 1'b1, 2'd1);
        req = 4'b0000; d1 = 5'h00;
        tick(); chk_all("hold_1", 4'b0000, 5'h15, 1'b1, 2'd1);
        req = 4'b0100;
        tick(); chk_all("hold_2", 4'b0000, 5'h15, 1'b1, 2'd1);
        q_ack = 1'b1;
        tick(); chk_all("hold_b2b", 4'b0100, 5'h03, 1'b1, 2'd2);
        req = 4'b0000;
        tick(); chk_all("hold_release", 4'b0000, 5'h03, 1'b0, 2'd2);

        // Same requester granted back-to-back (ptr is 3 here).
        req = 4'b0001; q_ack = 1'b0;
        tick(); chk_all("same_k", 4'b0001, 5'h01, 1'b1, 2'd0);
        q_ack = 1'b1; d0 = 5'h11;
        tick(); chk_all("same_k1", 4'b0001, 5'h11, 1'b1, 2'd0);
        q_ack = 1'b0; d0 = 5'h12;
        tick(); chk_all("same_k2", 4'b0000, 5'h11, 1'b1, 2'd0);
        q_ack = 1'b1;
        tick(); chk_all("same_k3", 4'b0001, 5'h12, 1'b1, 2'd0);
        req = 4'b0000;
        tick(); chk_all("same_release", 4'b0000, 5'h12, 1'b0, 2'd0);

        // Asynchronous reset mid-hold with q=1A and a live grant pulse.
        req = 4'b0001; d0 = 5'h1A; q_ack = 1'b0;
        tick(); chk_all("pre_rst", 4'b0001, 5'h1A, 1'b1, 2'd0);
        req = 4'b0000;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'b0000, 5'h00, 1'b0, 2'd0);
        #1 rst_n = 1'b1;

        // After release ptr is 0: requester 0 beats 2, then 2 alone.
        req = 4'b0101; d2 = 5'h07;
        tick(); chk_all("post_rst_ptr0", 4'b0001, 5'h1A, 1'b1, 2'd0);
        req = 4'b0100; q_ack = 1'b1;
        tick(); chk_all("post_rst_g2", 4'b0100, 5'h07, 1'b1, 2'd2);
        req = 4'b0000; q_ack = 1'b0;
        tick(); chk_all("post_rst_pulse", 4'b0000, 5'h07, 1'b1, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
